// File: rtl/cache_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl_if
//   Bundles every handshake/bus signal of the cache refill controller:
//   the LSU request/response, the tag-array lookup, the backing-RAM read
//   channel, the data/tag fill strobes and the performance counters.
//   The _i/_o suffixes are seen from the controller's side.
//   Modports:
//     slave  : the refill controller (serves LSU requests, drives the arrays)
//     master : the surrounding system (LSU, arrays, backing RAM, testbench)
// ---------------------------------------------------------------------------
interface cache_refill_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int MEM_DW  = 64
);
  localparam int BEATS  = 512 / MEM_DW;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // LSU request / response
  logic               req_valid_i;
  logic [ADDR_W-1:0]  req_addr_i;
  logic               req_ready_o;
  logic               resp_valid_o;
  logic [1:0]         resp_way_o;
  logic               resp_miss_o;
  // Tag-array lookup
  logic               lookup_o;
  logic [ADDR_W-1:0]  lookup_addr_o;
  logic               hit_i;
  logic [1:0]         hit_way_i;
  logic [3:0]         way_valid_i;
  // Backing-RAM read channel
  logic               mem_req_valid_o;
  logic               mem_req_ready_i;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic               mem_rvalid_i;
  logic [MEM_DW-1:0]  mem_rdata_i;
  // Data/tag array fill
  logic               fill_we_o;
  logic [INDEX_W-1:0] fill_index_o;
  logic [1:0]         fill_way_o;
  logic [BEAT_W-1:0]  fill_beat_o;
  logic [MEM_DW-1:0]  fill_data_o;
  logic               tag_we_o;
  // Performance counters
  logic [31:0]        perf_hit_o;
  logic [31:0]        perf_miss_o;

  modport slave (
    input  req_valid_i, req_addr_i, hit_i, hit_way_i, way_valid_i,
           mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_way_o, resp_miss_o,
           lookup_o, lookup_addr_o, mem_req_valid_o, mem_addr_o,
           fill_we_o, fill_index_o, fill_way_o, fill_beat_o, fill_data_o,
           tag_we_o, perf_hit_o, perf_miss_o
  );

  modport master (
    output req_valid_i, req_addr_i, hit_i, hit_way_i, way_valid_i,
           mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_way_o, resp_miss_o,
           lookup_o, lookup_addr_o, mem_req_valid_o, mem_addr_o,
           fill_we_o, fill_index_o, fill_way_o, fill_beat_o, fill_data_o,
           tag_we_o, perf_hit_o, perf_miss_o
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
//   Miss/refill sequencer for a 4-way, 2**INDEX_W-set L1 cache array.
//   Takes one LSU request at a time, strobes the tag lookup, picks a victim
//   on a miss (first invalid way, else tree-PLRU), reads the line from the
//   backing RAM in MEM_DW-bit beats, writes tag/valid only after the last
//   beat has been written and reports the resident way back to the LSU.
//   Owns the per-set PLRU bits {b2,b1,b0}.
// Ports:
//   clk_sys_i  system clock
//   rst_n_i    asynchronous active-low reset
//   bus        cache_refill_ctrl_if.slave (request/response, lookup,
//              backing-RAM read, fill strobes, perf counters)
// Build option:
//   CACHE_PERF_CNT_EN  when defined, saturating hit/miss counters are
//                      built; otherwise perf_hit_o/perf_miss_o are tied to 0.
// ---------------------------------------------------------------------------
module cache_refill_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 6,
  parameter int MEM_DW   = 64
) (
  input  logic clk_sys_i,
  input  logic rst_n_i,
  cache_refill_ctrl_if.slave bus
);
  localparam int BEATS  = 512 / MEM_DW;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SETS   = 1 << INDEX_W;

  localparam logic [BEAT_W:0]   RX_FULL   = (BEAT_W+1)'(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MREQ   = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         way_q;
  logic               miss_q;
  logic [2:0]         plru_q [SETS];
  logic [BEAT_W:0]    rx_cnt_q;
  logic               fill_we_q;
  logic [BEAT_W-1:0]  fill_beat_q;
  logic [MEM_DW-1:0]  fill_data_q;
  logic [INDEX_W-1:0] index_s;
  logic [1:0]         victim_s;

  // Way the tree points at: b0 selects the pair, b1/b2 the way inside it.
  function automatic logic [1:0] plru_victim(input logic [2:0] t);
    if (t[0]) begin
      plru_victim = t[2] ? 2'd3 : 2'd2;
    end else begin
      plru_victim = t[1] ? 2'd1 : 2'd0;
    end
  endfunction

  // Point the tree away from the accessed way; the other pair's bit is kept.
  function automatic logic [2:0] plru_touch(input logic [2:0] t, input logic [1:0] w);
    logic [2:0] n;
    n = t;
    case (w)
      2'd0:    begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1:    begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2:    begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

  assign index_s = addr_q[OFFSET_W +: INDEX_W];

  // Victim choice for the latched set: first invalid way wins over PLRU.
  always_comb begin
    if (!bus.way_valid_i[0]) begin
      victim_s = 2'd0;
    end else if (!bus.way_valid_i[1]) begin
      victim_s = 2'd1;
    end else if (!bus.way_valid_i[2]) begin
      victim_s = 2'd2;
    end else if (!bus.way_valid_i[3]) begin
      victim_s = 2'd3;
    end else begin
      victim_s = plru_victim(plru_q[index_s]);
    end
  end

  // Next-state logic of the request sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.req_valid_i ? S_LOOKUP : S_IDLE;
      S_LOOKUP: state_d = bus.hit_i ? S_RESP : S_MREQ;
      S_MREQ:   state_d = bus.mem_req_ready_i ? S_REFILL : S_MREQ;
      // Leave only once the final beat has actually been written.
      S_REFILL: state_d = (fill_we_q && (fill_beat_q == LAST_BEAT)) ? S_UPDATE : S_REFILL;
      S_UPDATE: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, latched request address and the way/miss result of the lookup.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      way_q   <= 2'd0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && bus.req_valid_i) begin
        addr_q <= bus.req_addr_i;
      end
      if (state_q == S_LOOKUP) begin
        miss_q <= ~bus.hit_i;
        way_q  <= bus.hit_i ? bus.hit_way_i : victim_s;
      end
    end
  end

  // Beat capture: registers each read beat; beats past the line are dropped.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_cnt_q    <= {(BEAT_W+1){1'b0}};
      fill_we_q   <= 1'b0;
      fill_beat_q <= {BEAT_W{1'b0}};
      fill_data_q <= {MEM_DW{1'b0}};
    end else begin
      fill_we_q <= 1'b0;
      if (state_q != S_REFILL) begin
        rx_cnt_q <= {(BEAT_W+1){1'b0}};
      end else if (bus.mem_rvalid_i && (rx_cnt_q < RX_FULL)) begin
        rx_cnt_q    <= rx_cnt_q + (BEAT_W+1)'(1);
        fill_we_q   <= 1'b1;
        fill_beat_q <= rx_cnt_q[BEAT_W-1:0];
        fill_data_q <= bus.mem_rdata_i;
      end
    end
  end

  // PLRU bookkeeping: hits update in LOOKUP, refilled victims in UPDATE.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= 3'b000;
      end
    end else if ((state_q == S_LOOKUP) && bus.hit_i) begin
      plru_q[index_s] <= plru_touch(plru_q[index_s], bus.hit_way_i);
    end else if (state_q == S_UPDATE) begin
      plru_q[index_s] <= plru_touch(plru_q[index_s], way_q);
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] perf_hit_q;
  logic [31:0] perf_miss_q;

  // Saturating hit/miss counters, stepped once per lookup.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_hit_q  <= 32'd0;
      perf_miss_q <= 32'd0;
    end else if (state_q == S_LOOKUP) begin
      if (bus.hit_i) begin
        if (perf_hit_q != 32'hFFFF_FFFF) perf_hit_q <= perf_hit_q + 32'd1;
      end else begin
        if (perf_miss_q != 32'hFFFF_FFFF) perf_miss_q <= perf_miss_q + 32'd1;
      end
    end
  end

  assign bus.perf_hit_o  = perf_hit_q;
  assign bus.perf_miss_o = perf_miss_q;
`else
  assign bus.perf_hit_o  = 32'd0;
  assign bus.perf_miss_o = 32'd0;
`endif

  assign bus.req_ready_o     = (state_q == S_IDLE);
  assign bus.lookup_o        = (state_q == S_LOOKUP);
  assign bus.lookup_addr_o   = addr_q;
  assign bus.mem_req_valid_o = (state_q == S_MREQ);
  assign bus.mem_addr_o      = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign bus.fill_we_o       = fill_we_q;
  assign bus.fill_index_o    = index_s;
  assign bus.fill_way_o      = way_q;
  assign bus.fill_beat_o     = fill_beat_q;
  assign bus.fill_data_o     = fill_data_q;
  assign bus.tag_we_o        = (state_q == S_UPDATE);
  assign bus.resp_valid_o    = (state_q == S_RESP);
  assign bus.resp_way_o      = way_q;
  assign bus.resp_miss_o     = miss_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_ctrl
//   Drives directed and randomized requests into cache_refill_ctrl and
//   compares every cycle of each transaction against a transaction-level
//   reference: per-set "most recently used pair / way within pair" state
//   stands in for the tree bits, and expected hit/miss counts are kept.
// ---------------------------------------------------------------------------
module tb_cache_refill_ctrl;
  localparam int BEATS = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   exp_hits;
  int   exp_misses;
  int   mru_pair [256];
  int   mru_in   [256][2];

  cache_refill_ctrl_if #(.ADDR_W(32), .INDEX_W(8), .MEM_DW(64)) bus ();

  cache_refill_ctrl #(.ADDR_W(32), .INDEX_W(8), .OFFSET_W(6), .MEM_DW(64)) dut (
    .clk_sys_i (clk),
    .rst_n_i   (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Fresh set: pair {2,3} and ways 1/3 count as most recent -> victim way0.
  task automatic model_reset();
    for (int s = 0; s < 256; s++) begin
      mru_pair[s]  = 1;
      mru_in[s][0] = 1;
      mru_in[s][1] = 1;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  function automatic int model_victim(input int s);
    int p;
    p = 1 - mru_pair[s];
    return 2 * p + (1 - mru_in[s][p]);
  endfunction

  task automatic model_touch(input int s, input int w);
    mru_pair[s]       = w / 2;
    mru_in[s][w / 2]  = w % 2;
  endtask

  task automatic check_perf();
`ifdef CACHE_PERF_CNT_EN
    check_eq("perf_hit", bus.perf_hit_o, 64'(exp_hits));
    check_eq("perf_miss", bus.perf_miss_o, 64'(exp_misses));
`else
    check_eq("perf_hit", bus.perf_hit_o, 64'd0);
    check_eq("perf_miss", bus.perf_miss_o, 64'd0);
`endif
  endtask

  // One complete request, entered and left at a negedge with the DUT idle.
  task automatic do_req(input logic [31:0] addr, input bit hit, input logic [1:0] hway,
                        input logic [3:0] wvalid, input int rdy_dly, input int first_gap,
                        input bit hold, input logic [31:0] next_addr, input int abort_beat);
    int          s;
    int          vic;
    int          sent;
    int          cyc;
    bit          done;
    logic        exp_we;
    int          exp_beat;
    logic [63:0] exp_data;
    s = int'(addr[13:6]);
    check_eq("req_ready_idle", bus.req_ready_o, 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.hit_i       = hit;
    bus.hit_way_i   = hway;
    bus.way_valid_i = wvalid;
    @(posedge clk); @(negedge clk);
    if (hold) begin
      bus.req_addr_i = next_addr;
    end else begin
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = $urandom;
    end
    check_eq("lookup", bus.lookup_o, 64'd1);
    check_eq("lookup_addr", bus.lookup_addr_o, 64'(addr));
    check_eq("req_ready_lookup", bus.req_ready_o, 64'd0);
    check_eq("resp_early", bus.resp_valid_o, 64'd0);
    if (hit) begin
      model_touch(s, int'(hway));
      exp_hits++;
      @(posedge clk); @(negedge clk);
      check_eq("hit_resp_valid", bus.resp_valid_o, 64'd1);
      check_eq("hit_resp_way", bus.resp_way_o, 64'(hway));
      check_eq("hit_resp_miss", bus.resp_miss_o, 64'd0);
      check_eq("hit_no_memreq", bus.mem_req_valid_o, 64'd0);
      check_eq("req_ready_resp", bus.req_ready_o, 64'd0);
      check_perf();
    end else begin
      vic = -1;
      for (int w = 3; w >= 0; w--) if (!wvalid[w]) vic = w;
      if (vic < 0) vic = model_victim(s);
      exp_misses++;
      @(posedge clk); @(negedge clk);
      for (int i = 0; i <= rdy_dly; i++) begin
        check_eq("mem_req_valid", bus.mem_req_valid_o, 64'd1);
        check_eq("mem_addr", bus.mem_addr_o, 64'(addr & 32'hFFFF_FFC0));
        check_eq("req_ready_mreq", bus.req_ready_o, 64'd0);
        bus.mem_req_ready_i = (i == rdy_dly);
        bus.mem_rvalid_i    = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
      end
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rvalid_i    = 1'b0;
      check_eq("single_mem_req", bus.mem_req_valid_o, 64'd0);
      exp_we = 1'b0; exp_beat = 0; exp_data = 64'd0; sent = 0; done = 1'b0; cyc = 0;
      while (!done && cyc < 300) begin
        check_eq("fill_we", bus.fill_we_o, 64'(exp_we));
        check_eq("tag_we_early", bus.tag_we_o, 64'd0);
        check_eq("req_ready_refill", bus.req_ready_o, 64'd0);
        if (exp_we) begin
          check_eq("fill_beat", bus.fill_beat_o, 64'(exp_beat));
          check_eq("fill_data", bus.fill_data_o, exp_data);
          check_eq("fill_way", bus.fill_way_o, 64'(vic));
          check_eq("fill_index", bus.fill_index_o, 64'(s));
          if (exp_beat == BEATS - 1) done = 1'b1;
          if (exp_beat == abort_beat) begin
            rst_n = 1'b0;
            bus.req_valid_i  = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            #1;
            model_reset();
            check_eq("rst_req_ready", bus.req_ready_o, 64'd1);
            check_eq("rst_fill_we", bus.fill_we_o, 64'd0);
            check_eq("rst_tag_we", bus.tag_we_o, 64'd0);
            check_eq("rst_resp_valid", bus.resp_valid_o, 64'd0);
            check_eq("rst_mem_req", bus.mem_req_valid_o, 64'd0);
            check_perf();
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 2; k++) begin
              @(posedge clk); @(negedge clk);
              check_eq("rst_no_tag_we", bus.tag_we_o, 64'd0);
            end
            return;
          end
        end
        if (done) begin
          bus.mem_rvalid_i = 1'($urandom_range(0, 1));
          exp_we = 1'b0;
        end else if (sent < BEATS && cyc >= first_gap && $urandom_range(0, 3) != 0) begin
          exp_data = {$urandom, $urandom};
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = exp_data;
          exp_we   = 1'b1;
          exp_beat = sent;
          sent++;
        end else begin
          bus.mem_rvalid_i = 1'b0;
          bus.mem_rdata_i  = {$urandom, $urandom};
          exp_we = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        cyc++;
      end
      bus.mem_rvalid_i = 1'b0;
      if (!done) check_eq("refill_timeout", 64'd0, 64'd1);
      check_eq("tag_we", bus.tag_we_o, 64'd1);
      check_eq("tag_index", bus.fill_index_o, 64'(s));
      check_eq("tag_way", bus.fill_way_o, 64'(vic));
      check_eq("fill_we_update", bus.fill_we_o, 64'd0);
      check_eq("resp_update", bus.resp_valid_o, 64'd0);
      model_touch(s, vic);
      @(posedge clk); @(negedge clk);
      check_eq("miss_resp_valid", bus.resp_valid_o, 64'd1);
      check_eq("miss_resp_way", bus.resp_way_o, 64'(vic));
      check_eq("miss_resp_miss", bus.resp_miss_o, 64'd1);
      check_eq("tag_we_resp", bus.tag_we_o, 64'd0);
      check_eq("req_ready_resp", bus.req_ready_o, 64'd0);
      check_perf();
    end
    @(posedge clk); @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int tag;
    int set;
    tag = $urandom_range(0, 15);
    set = 16 + 64 * $urandom_range(0, 3);
    return 32'((tag << 14) | (set << 6) | $urandom_range(0, 63));
  endfunction

  initial begin
    logic [31:0] cur_addr;
    logic [31:0] nxt_addr;
    bit          hold;
    bit          hit;
    logic [3:0]  wv;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_addr_i = 32'd0;
    bus.hit_i = 1'b0; bus.hit_way_i = 2'd0; bus.way_valid_i = 4'd0;
    bus.mem_req_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 64'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_req_ready", bus.req_ready_o, 64'd1);
    check_eq("reset_lookup", bus.lookup_o, 64'd0);
    check_eq("reset_mem_req", bus.mem_req_valid_o, 64'd0);
    check_eq("reset_fill_we", bus.fill_we_o, 64'd0);
    check_eq("reset_tag_we", bus.tag_we_o, 64'd0);
    check_eq("reset_resp", bus.resp_valid_o, 64'd0);
    check_eq("reset_resp_miss", bus.resp_miss_o, 64'd0);
    check_perf();
    rst_n = 1'b1;
    @(negedge clk);
    // Hit, way 2
    do_req(32'h0000_1040, 1'b1, 2'd2, 4'hF, 0, 0, 1'b0, 32'd0, -1);
    // Cold miss with ways 0/1 valid -> way 2
    do_req(32'h0000_2080, 1'b0, 2'd0, 4'b0011, 0, 2, 1'b0, 32'd0, -1);
    // Full-set misses on one set: way0, then way2
    do_req(32'h0000_3000, 1'b0, 2'd0, 4'hF, 0, 0, 1'b0, 32'd0, -1);
    do_req(32'h0004_3000, 1'b0, 2'd0, 4'hF, 0, 1, 1'b0, 32'd0, -1);
    // Backpressure on the line request
    do_req(32'h0000_4100, 1'b0, 2'd0, 4'hF, 5, 1, 1'b0, 32'd0, -1);
    // Second request held during a refill, taken right after RESP
    do_req(32'h0000_5000, 1'b0, 2'd0, 4'h7, 1, 3, 1'b1, 32'h0000_1040, -1);
    do_req(32'h0000_1040, 1'b1, 2'd1, 4'hF, 0, 0, 1'b0, 32'd0, -1);
    // Randomized traffic over a few sets
    nxt_addr = rand_addr();
    for (int t = 0; t < 60; t++) begin
      cur_addr = nxt_addr;
      nxt_addr = rand_addr();
      hold = ($urandom_range(0, 3) == 0);
      hit  = 1'($urandom_range(0, 1));
      wv   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      do_req(cur_addr, hit, 2'($urandom_range(0, 3)), wv, $urandom_range(0, 3),
             $urandom_range(0, 4), hold, nxt_addr, -1);
    end
    // Reset after beat 3 of a refill, then the set must start over at way0
    do_req(32'h0000_3000, 1'b0, 2'd0, 4'hF, 1, 0, 1'b0, 32'd0, 3);
    check_perf();
    do_req(32'h0008_3000, 1'b0, 2'd0, 4'hF, 0, 0, 1'b0, 32'd0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
